// File: rtl/scale_pkg.sv
// Shared types and defaults for the scaler parameter controller.
package scale_pkg;

  localparam int FRAC_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV_H,
    ST_DIV_V,
    ST_PEND
  } state_t;

  typedef enum logic {
    MODE_BYPASS = 1'b0,
    MODE_SCALE  = 1'b1
  } mode_t;

endpackage

// File: rtl/seq_div_u.sv
// Unsigned restoring divider: one quotient bit per cycle, N_W cycles per divide.
// done is high during the cycle that performs the final step; quotient holds
// the completed result in that same cycle, so a new start may be issued then.
module seq_div_u #(
  parameter int N_W = 19,
  parameter int D_W = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic           div_zero
);

  localparam int CW = $clog2(N_W + 1);

  logic [CW-1:0]  cnt;
  logic [D_W-1:0] rem;
  logic [D_W-1:0] dsr;
  logic [N_W-1:0] quo;
  logic [D_W:0]   trial;
  logic [D_W:0]   diff;
  logic [D_W-1:0] rem_next;
  logic [N_W-1:0] quo_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial = {rem, quo[N_W-1]};
    diff  = trial - {1'b0, dsr};
    if (trial >= {1'b0, dsr}) begin
      rem_next = diff[D_W-1:0];
      quo_next = {quo[N_W-2:0], 1'b1};
    end else begin
      rem_next = trial[D_W-1:0];
      quo_next = {quo[N_W-2:0], 1'b0};
    end
  end

  assign done     = (cnt == CW'(1));
  assign quotient = quo_next;

  // Load on start (start wins over a step in progress), otherwise iterate.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      dsr      <= '0;
      quo      <= '0;
      div_zero <= 1'b0;
    end else if (start) begin
      cnt      <= CW'(N_W);
      rem      <= '0;
      dsr      <= divisor;
      quo      <= dividend;
      div_zero <= (divisor == '0);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      rem <= rem_next;
      quo <= quo_next;
    end
  end

endmodule

// File: rtl/scale_para_ctrl.sv
// Scaler parameter controller: accepts a config, computes fixed-point scale
// factors with a shared sequential divider, and commits all active outputs
// together on the first vsync falling edge seen while pending.
module scale_para_ctrl
  import scale_pkg::*;
#(
  parameter int DIM_W       = 11,
  parameter int FRAC_W      = FRAC_W_DEF,
  parameter int K_W         = 16,
  parameter int ADDR_W      = 28,
  parameter int BURST_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vsync,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic                       cfg_mode,
  input  logic [DIM_W-1:0]           s_width,
  input  logic [DIM_W-1:0]           s_height,
  input  logic [DIM_W-1:0]           t_width,
  input  logic [DIM_W-1:0]           t_height,
  output logic                       act_mode,
  output logic [DIM_W-1:0]           act_t_width,
  output logic [DIM_W-1:0]           act_t_height,
  output logic [K_W-1:0]             h_scale_k,
  output logic [K_W-1:0]             v_scale_k,
  output logic [DIM_W-BURST_SHIFT-1:0] burst_len,
  output logic [ADDR_W-1:0]          addr_max,
  output logic                       busy,
  output logic                       cfg_err,
  output logic                       commit
);

  localparam int N_W = DIM_W + FRAC_W;
  localparam logic [K_W-1:0] K_ONE = K_W'(1) << FRAC_W;

  function automatic logic [K_W-1:0] sat_k(input logic [N_W-1:0] q);
    logic [N_W+K_W-1:0] qx;
    qx = {{K_W{1'b0}}, q};
    if ((qx >> K_W) != '0) return '1;
    return qx[K_W-1:0];
  endfunction

  state_t         state, state_next;
  mode_t          sh_mode;
  logic [DIM_W-1:0] sh_sw, sh_sh, sh_tw, sh_th;
  logic [K_W-1:0] sh_hk, sh_vk;
  logic           vsync_d, boundary;
  logic           accept, start_div, cap_h, cap_v, do_commit, cfg_bad;
  logic           div_done, div_zero;
  logic [N_W-1:0] div_q, div_dividend;
  logic [DIM_W-1:0] div_divisor, eff_w, eff_h;
  logic [2*DIM_W-1:0] area;

  assign boundary = vsync_d & ~vsync;
  assign accept   = (state == ST_IDLE) && cfg_valid;

  // H divide starts straight from the ports on accept; V reuses the divider
  // from the shadow registers in the same cycle H finishes.
  assign div_dividend = (state == ST_IDLE) ? {s_width, {FRAC_W{1'b0}}}
                                           : {sh_sh, {FRAC_W{1'b0}}};
  assign div_divisor  = (state == ST_IDLE) ? t_width : sh_th;

  assign eff_w = (sh_mode == MODE_SCALE) ? sh_tw : sh_sw;
  assign eff_h = (sh_mode == MODE_SCALE) ? sh_th : sh_sh;
  assign area  = (2*DIM_W)'(eff_w) * (2*DIM_W)'(eff_h);

  seq_div_u #(.N_W(N_W), .D_W(DIM_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start_div),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_q),
    .div_zero (div_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next = state;
    start_div  = 1'b0;
    cap_h      = 1'b0;
    cap_v      = 1'b0;
    do_commit  = 1'b0;
    cfg_bad    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cfg_mode == MODE_SCALE) begin
            start_div  = 1'b1;
            cfg_bad    = (t_width == '0) || (t_height == '0);
            state_next = ST_DIV_H;
          end else begin
            state_next = ST_PEND;
          end
        end
      end
      ST_DIV_H: begin
        if (div_zero || (sh_th == '0)) begin
          state_next = ST_IDLE;
        end else if (div_done) begin
          cap_h      = 1'b1;
          start_div  = 1'b1;
          state_next = ST_DIV_V;
        end
      end
      ST_DIV_V: begin
        if (div_done) begin
          cap_v      = 1'b1;
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        if (boundary) begin
          do_commit  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shadow config and computed factors awaiting the frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_mode <= MODE_BYPASS;
      sh_sw   <= '0;
      sh_sh   <= '0;
      sh_tw   <= '0;
      sh_th   <= '0;
      sh_hk   <= K_ONE;
      sh_vk   <= K_ONE;
    end else begin
      if (accept) begin
        sh_mode <= mode_t'(cfg_mode);
        sh_sw   <= s_width;
        sh_sh   <= s_height;
        sh_tw   <= t_width;
        sh_th   <= t_height;
      end
      if (cap_h) sh_hk <= sat_k(div_q);
      if (cap_v) sh_vk <= sat_k(div_q);
    end
  end

  // Registered status, pulses, and the active set updated only on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d      <= 1'b0;
      cfg_ready    <= 1'b1;
      busy         <= 1'b0;
      cfg_err      <= 1'b0;
      commit       <= 1'b0;
      act_mode     <= 1'b0;
      act_t_width  <= '0;
      act_t_height <= '0;
      h_scale_k    <= K_ONE;
      v_scale_k    <= K_ONE;
      burst_len    <= '0;
      addr_max     <= '0;
    end else begin
      vsync_d   <= vsync;
      cfg_ready <= (state_next == ST_IDLE);
      busy      <= (state_next != ST_IDLE);
      cfg_err   <= cfg_bad;
      commit    <= do_commit;
      if (do_commit) begin
        act_mode     <= (sh_mode == MODE_SCALE);
        act_t_width  <= eff_w;
        act_t_height <= eff_h;
        h_scale_k    <= (sh_mode == MODE_SCALE) ? sh_hk : K_ONE;
        v_scale_k    <= (sh_mode == MODE_SCALE) ? sh_vk : K_ONE;
        burst_len    <= eff_w[DIM_W-1:BURST_SHIFT];
        addr_max     <= ADDR_W'(area);
      end
    end
  end

endmodule

// File: tb/tb_scale_para_ctrl.sv
// Bench for scale_para_ctrl: transaction-level model plus directed literals
// and a randomized soak.
module tb_scale_para_ctrl;

  localparam int DIM_W = 11, FRAC_W = 8, K_W = 16, ADDR_W = 28, BURST_SHIFT = 3;
  localparam int DIV_CYCLES = 2 * (DIM_W + FRAC_W);
  localparam int K_MAX = (1 << K_W) - 1;
  localparam int K_ONE = 1 << FRAC_W;

  logic clk = 0, rst = 1, vsync = 0, cfg_valid = 0, cfg_mode = 0;
  logic [DIM_W-1:0] s_width = '0, s_height = '0, t_width = '0, t_height = '0;
  logic cfg_ready, act_mode, busy, cfg_err, commit;
  logic [DIM_W-1:0] act_t_width, act_t_height;
  logic [K_W-1:0] h_scale_k, v_scale_k;
  logic [DIM_W-BURST_SHIFT-1:0] burst_len;
  logic [ADDR_W-1:0] addr_max;

  always #5 clk = ~clk;

  scale_para_ctrl #(
    .DIM_W(DIM_W), .FRAC_W(FRAC_W), .K_W(K_W), .ADDR_W(ADDR_W), .BURST_SHIFT(BURST_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .s_width(s_width), .s_height(s_height), .t_width(t_width),
    .t_height(t_height), .act_mode(act_mode), .act_t_width(act_t_width),
    .act_t_height(act_t_height), .h_scale_k(h_scale_k), .v_scale_k(v_scale_k),
    .burst_len(burst_len), .addr_max(addr_max), .busy(busy), .cfg_err(cfg_err),
    .commit(commit)
  );

  int n_checks = 0, n_pass = 0;
  int commits_seen = 0, errs_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int kdiv(input int s, input int t);
    int q;
    q = (s * K_ONE) / t;
    return (q > K_MAX) ? K_MAX : q;
  endfunction

  // Model: a config either waits out the fixed divide latency or fails at once,
  // then waits for a vsync fall and publishes everything at once.
  int m_phase = 0, m_left = 0, m_mode = 0;
  int m_sw = 0, m_sh = 0, m_tw = 0, m_th = 0, m_hk = K_ONE, m_vk = K_ONE;
  bit m_abort = 0, m_vsd = 0, bnd;
  int e_ready = 1, e_busy = 0, e_err = 0, e_commit = 0, e_mode = 0, e_tw = 0, e_th = 0;
  int e_hk = K_ONE, e_vk = K_ONE, e_burst = 0, e_addr = 0;

  always @(posedge clk) begin : model
    if (rst) begin
      m_phase = 0; m_vsd = 0;
      e_ready = 1; e_busy = 0; e_err = 0; e_commit = 0; e_mode = 0;
      e_tw = 0; e_th = 0; e_hk = K_ONE; e_vk = K_ONE; e_burst = 0; e_addr = 0;
    end else begin
      bnd = m_vsd && !vsync;
      m_vsd = vsync;
      e_err = 0;
      e_commit = 0;
      case (m_phase)
        0: if (cfg_valid) begin
          m_mode = cfg_mode; m_sw = s_width; m_sh = s_height; m_tw = t_width; m_th = t_height;
          if (cfg_mode) begin
            m_phase = 1;
            if (t_width == 0 || t_height == 0) begin
              e_err = 1; m_abort = 1; m_left = 1;
            end else begin
              m_abort = 0; m_left = DIV_CYCLES;
              m_hk = kdiv(m_sw, m_tw); m_vk = kdiv(m_sh, m_th);
            end
          end else begin
            m_hk = K_ONE; m_vk = K_ONE; m_phase = 2;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = m_abort ? 0 : 2;
        end
        default: if (bnd) begin
          e_commit = 1; e_mode = m_mode;
          e_tw = m_mode ? m_tw : m_sw;
          e_th = m_mode ? m_th : m_sh;
          e_hk = m_hk; e_vk = m_vk;
          e_burst = e_tw >> BURST_SHIFT;
          e_addr = e_tw * e_th;
          m_phase = 0;
        end
      endcase
      e_ready = (m_phase == 0) ? 1 : 0;
      e_busy = 1 - e_ready;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk) begin : compare
    #2;
    chk("cfg_ready", cfg_ready, e_ready);
    chk("busy", busy, e_busy);
    chk("cfg_err", cfg_err, e_err);
    chk("commit", commit, e_commit);
    chk("act_mode", act_mode, e_mode);
    chk("act_t_width", act_t_width, e_tw);
    chk("act_t_height", act_t_height, e_th);
    chk("h_scale_k", h_scale_k, e_hk);
    chk("v_scale_k", v_scale_k, e_vk);
    chk("burst_len", burst_len, e_burst);
    chk("addr_max", addr_max, e_addr);
    if (commit === 1'b1) commits_seen++;
    if (cfg_err === 1'b1) errs_seen++;
  end

  task automatic send_cfg(input bit mode, input int sw, input int sh, input int tw, input int th);
    int n;
    n = 0;
    @(negedge clk);
    while (cfg_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", cfg_ready, 1);
    cfg_mode = mode;
    s_width = DIM_W'(sw); s_height = DIM_W'(sh); t_width = DIM_W'(tw); t_height = DIM_W'(th);
    cfg_valid = 1;
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic vsync_fall();
    @(negedge clk); vsync = 1;
    @(negedge clk); vsync = 0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, cfg_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_hk"}, h_scale_k, K_ONE);
    chk({tag, "_vk"}, v_scale_k, K_ONE);
    chk({tag, "_addr"}, addr_max, 0);
    chk({tag, "_tw"}, act_t_width, 0);
    chk({tag, "_commit"}, commit, 0);
  endtask

  int c0, e0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    chk_reset_vals("reset");

    // 1280x720 -> 1024x768
    c0 = commits_seen;
    send_cfg(1, 1280, 720, 1024, 768);
    repeat (40) @(negedge clk);
    chk("pend_busy", busy, 1);
    chk("pend_no_commit", commits_seen - c0, 0);
    vsync_fall();
    chk("s1_commit", commit, 1);
    chk("s1_hk", h_scale_k, 320);
    chk("s1_vk", v_scale_k, 240);
    chk("s1_burst", burst_len, 128);
    chk("s1_addr", addr_max, 786432);
    chk("s1_mode", act_mode, 1);
    @(negedge clk);
    chk("s1_commit_end", commit, 0);
    chk("s1_commit_count", commits_seen - c0, 1);

    // bypass 640x480
    send_cfg(0, 640, 480, 0, 0);
    vsync_fall();
    chk("byp_hk", h_scale_k, 256);
    chk("byp_vk", v_scale_k, 256);
    chk("byp_tw", act_t_width, 640);
    chk("byp_th", act_t_height, 480);
    chk("byp_burst", burst_len, 80);
    chk("byp_addr", addr_max, 307200);
    chk("byp_mode", act_mode, 0);

    // zero target width
    e0 = errs_seen;
    c0 = commits_seen;
    send_cfg(1, 800, 600, 0, 600);
    chk("err_pulse", cfg_err, 1);
    chk("err_not_ready", cfg_ready, 0);
    @(negedge clk);
    chk("err_end", cfg_err, 0);
    chk("err_ready", cfg_ready, 1);
    chk("err_count", errs_seen - e0, 1);
    vsync_fall();
    chk("err_tw_kept", act_t_width, 640);
    chk("err_addr_kept", addr_max, 307200);
    chk("err_no_commit", commits_seen - c0, 0);

    // vsync fall during DIV_H is ignored
    c0 = commits_seen;
    send_cfg(1, 1920, 1080, 1280, 720);
    @(negedge clk);
    @(negedge clk); vsync = 1;
    @(negedge clk); vsync = 0;
    repeat (45) @(negedge clk);
    chk("early_vs_no_commit", commits_seen - c0, 0);
    chk("early_vs_tw_kept", act_t_width, 640);
    vsync_fall();
    chk("late_vs_commit", commits_seen - c0, 1);
    chk("late_vs_hk", h_scale_k, 384);
    chk("late_vs_vk", v_scale_k, 384);

    // reset during DIV_V
    c0 = commits_seen;
    send_cfg(1, 1000, 500, 500, 250);
    repeat (25) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_reset_vals("midrst");
    vsync_fall();
    vsync_fall();
    chk("midrst_no_commit", commits_seen - c0, 0);
    chk("midrst_ready", cfg_ready, 1);

    // saturation
    send_cfg(1, 2047, 100, 1, 50);
    repeat (40) @(negedge clk);
    vsync_fall();
    chk("sat_hk", h_scale_k, 65535);
    chk("sat_vk", v_scale_k, 512);
    chk("sat_burst", burst_len, 0);
    chk("sat_addr", addr_max, 50);

    // randomized soak
    c0 = commits_seen;
    for (int i = 0; i < 4000; i++) begin
      int r;
      @(negedge clk);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_mode = 1'($urandom_range(0, 1));
      s_width = DIM_W'($urandom_range(0, 2047));
      s_height = DIM_W'($urandom_range(0, 2047));
      r = $urandom_range(0, 9);
      t_width = (r == 0) ? '0 : (r < 4) ? DIM_W'($urandom_range(1, 16)) : DIM_W'($urandom_range(1, 2047));
      r = $urandom_range(0, 9);
      t_height = (r == 0) ? '0 : (r < 4) ? DIM_W'($urandom_range(1, 16)) : DIM_W'($urandom_range(1, 2047));
      if ($urandom_range(0, 24) == 0) vsync = ~vsync;
      rst = ($urandom_range(0, 699) == 0);
    end
    @(negedge clk);
    rst = 0;
    cfg_valid = 0;
    repeat (3) @(negedge clk);
    chk("random_commits_seen", (commits_seen > c0) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
